// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory arbiter: FSM states,
// access-owner encoding and default latency/fairness constants.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_MAX = 4;

  // Counter width able to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/unified_mem_arbiter.sv
// Arbitrates fetch and memory-stage accesses onto one single-ported,
// fixed-latency memory; one access in flight, sequenced IDLE->ISSUE->WAIT->RESP.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 32,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  localparam int WW        = cnt_width(MEM_LAT),
  localparam int SW        = cnt_width(STARVE_MAX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [XLEN-1:0]   if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [XLEN-1:0]   dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [XLEN-1:0]   dm_rdata,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  output state_e            dbg_state,
  output logic [SW-1:0]     dbg_starve_cnt
);

  // Handshake: a requester holds x_req with stable fields until the cycle
  // x_gnt is high (combinational, IDLE only); x_rvalid later pulses once.

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [WW-1:0]       wait_q, wait_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [XLEN-1:0]     if_rdata_q, if_rdata_d;
  logic [XLEN-1:0]     dm_rdata_q, dm_rdata_d;
  logic                pick_dm;
  logic                busy;

  // DM wins ties until IF has been passed over STARVE_MAX times in a row.
  assign pick_dm = dm_req && !(if_req && (starve_q == SW'(STARVE_MAX)));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wait_d     = wait_q;
    starve_d   = starve_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_gnt     = 1'b0;
    dm_gnt     = 1'b0;
    mem_en     = 1'b0;
    if_rvalid  = 1'b0;
    dm_rvalid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_dm) begin
          dm_gnt  = 1'b1;
          owner_d = OWN_DM;
          addr_d  = dm_addr;
          we_d    = dm_we;
          wdata_d = dm_wdata;
          state_d = S_ISSUE;
          if (!if_req) begin
            starve_d = '0;
          end else if (starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
          end
        end else if (if_req) begin
          if_gnt   = 1'b1;
          owner_d  = OWN_IF;
          addr_d   = if_addr;
          we_d     = 1'b0;
          starve_d = '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_en  = 1'b1;
        wait_d  = WW'(MEM_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wait_d = wait_q - 1'b1;
        if (wait_q == WW'(1)) begin
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
          end else if (!we_q) begin
            dm_rdata_d = mem_rdata;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if_rvalid = (owner_q == OWN_IF);
        dm_rvalid = (owner_q == OWN_DM);
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_IF;
      wait_q     <= '0;
      starve_q   <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wait_q     <= wait_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign busy           = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign stall_if       = if_req || (busy && (owner_q == OWN_IF));
  assign stall_dm       = dm_req || (busy && (owner_q == OWN_DM));
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign if_rdata       = if_rdata_q;
  assign dm_rdata       = dm_rdata_q;
  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: per-cycle vector table plus
// sequences for starvation, reset mid-access and a MEM_LAT=1 instance.
module tb_unified_mem_arbiter;
  import mem_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (MEM_LAT=2) ----------------
  logic        if_req, if_gnt, if_rvalid, dm_req, dm_we, dm_gnt, dm_rvalid;
  logic        stall_if, stall_dm, mem_en, mem_we;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  state_e      dbg_state;
  logic [2:0]  dbg_starve_cnt;

  unified_mem_arbiter #(.MEM_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .stall_if(stall_if), .stall_dm(stall_dm),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- DUT (MEM_LAT=1) ----------------
  logic        if_req1, if_gnt1, if_rvalid1, dm_gnt1, dm_rvalid1;
  logic        stall_if1, stall_dm1, mem_en1, mem_we1;
  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  state_e      dbg_state1;
  logic [2:0]  dbg_starve_cnt1;

  unified_mem_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(32'h40), .if_gnt(if_gnt1),
    .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .dm_req(1'b0), .dm_we(1'b0), .dm_addr(32'h0), .dm_wdata(32'h0),
    .dm_gnt(dm_gnt1), .dm_rvalid(dm_rvalid1), .dm_rdata(dm_rdata1),
    .stall_if(stall_if1), .stall_dm(stall_dm1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1),
    .dbg_state(dbg_state1), .dbg_starve_cnt(dbg_starve_cnt1)
  );

  // ---------------- memory models ----------------
  // Read data is driven only in the cycle exactly LAT cycles after mem_en;
  // every other cycle carries a junk pattern.
  logic [31:0] store_m [logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a == 32'h40) ? 32'h0050_0093 : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return store_m.exists(a) ? store_m[a] : dflt(a);
  endfunction

  int          tgt = -1, tgt1 = -1;
  logic [31:0] pdat, pdat1;
  initial begin
    mem_rdata  = 32'h0;
    mem_rdata1 = 32'h0;
  end
  always @(negedge clk) begin
    if (mem_en) begin
      if (mem_we) store_m[mem_addr] = mem_wdata;
      else begin
        tgt  = cyc + 2;
        pdat = mem_rd(mem_addr);
      end
    end
    mem_rdata = (cyc == tgt) ? pdat : (32'hBADB_AD00 ^ 32'(cyc));
    if (mem_en1) begin
      tgt1  = cyc + 1;
      pdat1 = dflt(mem_addr1);
    end
    mem_rdata1 = (cyc == tgt1) ? pdat1 : (32'h0BAD_0000 ^ 32'(cyc));
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        e_if_gnt, e_dm_gnt, e_mem_en, e_mem_we;
    logic [31:0] e_mem_addr;
    logic        e_if_rv, e_dm_rv;
    logic [31:0] e_if_rdata, e_dm_rdata;
    logic        e_stall_if, e_stall_dm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
    input logic [31:0] da, input logic [31:0] dd,
    input logic ig, input logic dg, input logic en, input logic we,
    input logic [31:0] ma, input logic irv, input logic drv,
    input logic [31:0] ird, input logic [31:0] drd, input logic sif, input logic sdm);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_we = dw;
    v.dm_addr = da; v.dm_wdata = dd;
    v.e_if_gnt = ig; v.e_dm_gnt = dg; v.e_mem_en = en; v.e_mem_we = we;
    v.e_mem_addr = ma; v.e_if_rv = irv; v.e_dm_rv = drv;
    v.e_if_rdata = ird; v.e_dm_rdata = drd; v.e_stall_if = sif; v.e_stall_dm = sdm;
    return v;
  endfunction

  localparam logic [31:0] D    = 32'h0050_0093;
  localparam logic [31:0] B    = 32'hDEAD_BEEF;
  localparam logic [31:0] R104 = 32'h0104 ^ 32'hA5A5_0000;
  localparam logic [31:0] R44  = 32'h0044 ^ 32'hA5A5_0000;

  task automatic build_table();
    // IF read of 0x40, grant at T=0
    vecs.push_back(mk(1, 'h40, 0, 0, 0, 0,   1, 0, 0, 0, 'h0,   0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 'h0,  0, 0, 0, 0,   0, 0, 1, 0, 'h40,  0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 'h0,  0, 0, 0, 0,   0, 0, 0, 0, 'h40,  0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 'h0,  0, 0, 0, 0,   0, 0, 0, 0, 'h40,  0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 'h0,  0, 0, 0, 0,   0, 0, 0, 0, 'h40,  1, 0, D, 0, 0, 0));
    vecs.push_back(mk(0, 'h0,  0, 0, 0, 0,   0, 0, 0, 0, 'h40,  0, 0, D, 0, 0, 0));
    // DM store of 0xDEADBEEF to 0x100
    vecs.push_back(mk(0, 'h0,  1, 1, 'h100, B, 0, 1, 0, 0, 'h40,  0, 0, D, 0, 0, 1));
    vecs.push_back(mk(0, 'h0,  0, 0, 0, 0,   0, 0, 1, 1, 'h100, 0, 0, D, 0, 0, 1));
    vecs.push_back(mk(0, 'h0,  0, 0, 0, 0,   0, 0, 0, 1, 'h100, 0, 0, D, 0, 0, 1));
    vecs.push_back(mk(0, 'h0,  0, 0, 0, 0,   0, 0, 0, 1, 'h100, 0, 0, D, 0, 0, 1));
    vecs.push_back(mk(0, 'h0,  0, 0, 0, 0,   0, 0, 0, 1, 'h100, 0, 1, D, 0, 0, 0));
    // DM load back from 0x100
    vecs.push_back(mk(0, 'h0,  1, 0, 'h100, 0, 0, 1, 0, 1, 'h100, 0, 0, D, 0, 0, 1));
    vecs.push_back(mk(0, 'h0,  0, 0, 0, 0,   0, 0, 1, 0, 'h100, 0, 0, D, 0, 0, 1));
    vecs.push_back(mk(0, 'h0,  0, 0, 0, 0,   0, 0, 0, 0, 'h100, 0, 0, D, 0, 0, 1));
    vecs.push_back(mk(0, 'h0,  0, 0, 0, 0,   0, 0, 0, 0, 'h100, 0, 0, D, 0, 0, 1));
    vecs.push_back(mk(0, 'h0,  0, 0, 0, 0,   0, 0, 0, 0, 'h100, 0, 1, D, B, 0, 0));
    // tie: DM load 0x104 first, IF read 0x44 granted in the next IDLE (T+5)
    vecs.push_back(mk(1, 'h44, 1, 0, 'h104, 0, 0, 1, 0, 0, 'h100, 0, 0, D, B, 1, 1));
    vecs.push_back(mk(1, 'h44, 0, 0, 0, 0,   0, 0, 1, 0, 'h104, 0, 0, D, B, 1, 1));
    vecs.push_back(mk(1, 'h44, 0, 0, 0, 0,   0, 0, 0, 0, 'h104, 0, 0, D, B, 1, 1));
    vecs.push_back(mk(1, 'h44, 0, 0, 0, 0,   0, 0, 0, 0, 'h104, 0, 0, D, B, 1, 1));
    vecs.push_back(mk(1, 'h44, 0, 0, 0, 0,   0, 0, 0, 0, 'h104, 0, 1, D, R104, 1, 0));
    vecs.push_back(mk(1, 'h44, 0, 0, 0, 0,   1, 0, 0, 0, 'h104, 0, 0, D, R104, 1, 0));
    vecs.push_back(mk(0, 'h0,  0, 0, 0, 0,   0, 0, 1, 0, 'h44,  0, 0, D, R104, 1, 0));
    vecs.push_back(mk(0, 'h0,  0, 0, 0, 0,   0, 0, 0, 0, 'h44,  0, 0, D, R104, 1, 0));
    vecs.push_back(mk(0, 'h0,  0, 0, 0, 0,   0, 0, 0, 0, 'h44,  0, 0, D, R104, 1, 0));
    vecs.push_back(mk(0, 'h0,  0, 0, 0, 0,   0, 0, 0, 0, 'h44,  1, 0, R44, R104, 0, 0));
    vecs.push_back(mk(0, 'h0,  0, 0, 0, 0,   0, 0, 0, 0, 'h44,  0, 0, R44, R104, 0, 0));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".if_gnt"},    32'(if_gnt),    32'h0);
    chk({tag, ".dm_gnt"},    32'(dm_gnt),    32'h0);
    chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'h0);
    chk({tag, ".dm_rvalid"}, 32'(dm_rvalid), 32'h0);
    chk({tag, ".if_rdata"},  if_rdata,       32'h0);
    chk({tag, ".dm_rdata"},  dm_rdata,       32'h0);
    chk({tag, ".stall_if"},  32'(stall_if),  32'h0);
    chk({tag, ".stall_dm"},  32'(stall_dm),  32'h0);
    chk({tag, ".mem_en"},    32'(mem_en),    32'h0);
    chk({tag, ".mem_we"},    32'(mem_we),    32'h0);
    chk({tag, ".mem_addr"},  mem_addr,       32'h0);
    chk({tag, ".mem_wdata"}, mem_wdata,      32'h0);
    chk({tag, ".state"},     32'(dbg_state), 32'h0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main test ----------------
  initial begin
    owner_e exp_seq[6];
    int     exp_st[6];
    int     gcyc[6];
    int     ng, pend, rv_seen, t_rv, t_g;
    int     g1[2];
    int     ng1;
    logic [31:0] rd1;

    exp_seq = '{OWN_DM, OWN_DM, OWN_DM, OWN_DM, OWN_IF, OWN_DM};
    exp_st  = '{1, 2, 3, 4, 0, 1};

    rst = 1'b1;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    if_req1 = 0;
    #2 rst = 1'b0;
    #1 check_all_zero("reset");
    chk("reset.starve", 32'(dbg_starve_cnt), 32'h0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    next_cycle();

    // table-driven cycles
    build_table();
    foreach (vecs[i]) begin
      if_req = vecs[i].if_req;   if_addr  = vecs[i].if_addr;
      dm_req = vecs[i].dm_req;   dm_we    = vecs[i].dm_we;
      dm_addr = vecs[i].dm_addr; dm_wdata = vecs[i].dm_wdata;
      @(negedge clk);
      chk($sformatf("v%0d.if_gnt", i),    32'(if_gnt),    32'(vecs[i].e_if_gnt));
      chk($sformatf("v%0d.dm_gnt", i),    32'(dm_gnt),    32'(vecs[i].e_dm_gnt));
      chk($sformatf("v%0d.mem_en", i),    32'(mem_en),    32'(vecs[i].e_mem_en));
      chk($sformatf("v%0d.mem_we", i),    32'(mem_we),    32'(vecs[i].e_mem_we));
      chk($sformatf("v%0d.mem_addr", i),  mem_addr,       vecs[i].e_mem_addr);
      chk($sformatf("v%0d.if_rvalid", i), 32'(if_rvalid), 32'(vecs[i].e_if_rv));
      chk($sformatf("v%0d.dm_rvalid", i), 32'(dm_rvalid), 32'(vecs[i].e_dm_rv));
      chk($sformatf("v%0d.if_rdata", i),  if_rdata,       vecs[i].e_if_rdata);
      chk($sformatf("v%0d.dm_rdata", i),  dm_rdata,       vecs[i].e_dm_rdata);
      chk($sformatf("v%0d.stall_if", i),  32'(stall_if),  32'(vecs[i].e_stall_if));
      chk($sformatf("v%0d.stall_dm", i),  32'(stall_dm),  32'(vecs[i].e_stall_dm));
      if (vecs[i].e_mem_en && vecs[i].e_mem_we)
        chk($sformatf("v%0d.mem_wdata", i), mem_wdata, B);
      next_cycle();
    end

    // starvation: both sides request continuously
    if_req = 1; if_addr = 32'h48; dm_req = 1; dm_we = 0; dm_addr = 32'h108;
    ng = 0; pend = -1;
    for (int c = 0; c < 60 && (ng < 6 || pend >= 0); c++) begin
      @(negedge clk);
      if (pend >= 0) begin
        chk($sformatf("starve.cnt%0d", pend), 32'(dbg_starve_cnt), 32'(exp_st[pend]));
        pend = -1;
      end
      if ((if_gnt || dm_gnt) && ng < 6) begin
        chk($sformatf("starve.grant%0d", ng), 32'(if_gnt ? OWN_IF : OWN_DM), 32'(exp_seq[ng]));
        gcyc[ng] = cyc;
        if (ng > 0) chk($sformatf("starve.gap%0d", ng), 32'(gcyc[ng] - gcyc[ng-1]), 32'd5);
        pend = ng;
        ng++;
        if (ng == 6) begin
          next_cycle();
          if_req = 0; dm_req = 0;
          continue;
        end
      end
      next_cycle();
    end
    chk("starve.grant_count", 32'(ng), 32'd6);
    if_req = 0; dm_req = 0;
    repeat (8) next_cycle();

    // reset during WAIT of a DM load
    dm_req = 1; dm_we = 0; dm_addr = 32'h100;
    @(negedge clk);
    chk("rstwait.dm_gnt", 32'(dm_gnt), 32'h1);
    next_cycle();
    dm_req = 0;
    next_cycle();
    chk("rstwait.in_wait", 32'(dbg_state), 32'(S_WAIT));
    #2 rst = 1'b0;
    #1 check_all_zero("rstwait");
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    next_cycle();
    rv_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (dm_rvalid) rv_seen++;
      next_cycle();
    end
    chk("rstwait.no_dm_rvalid", 32'(rv_seen), 32'h0);
    if_req = 1; if_addr = 32'h40;
    @(negedge clk);
    chk("rstwait.if_gnt", 32'(if_gnt), 32'h1);
    next_cycle();
    if_req = 0;
    t_rv = -1;
    for (int c = 0; c < 10 && t_rv < 0; c++) begin
      @(negedge clk);
      if (if_rvalid) begin
        t_rv = c;
        chk("rstwait.if_rdata", if_rdata, D);
      end
      next_cycle();
    end
    chk("rstwait.if_rvalid_cycle", 32'(t_rv), 32'd3);

    // MEM_LAT=1: latency 3, back-to-back spacing 4
    if_req1 = 1;
    ng1 = 0; t_rv = -1; t_g = -1; rd1 = 32'h0;
    for (int c = 0; c < 20 && ng1 < 2; c++) begin
      @(negedge clk);
      if (if_gnt1) begin
        g1[ng1] = cyc;
        ng1++;
      end
      if (if_rvalid1 && t_rv < 0) begin
        t_rv = cyc;
        rd1  = if_rdata1;
      end
      next_cycle();
    end
    if_req1 = 0;
    chk("lat1.grant_count", 32'(ng1), 32'd2);
    if (ng1 == 2) begin
      t_g = g1[0];
      chk("lat1.latency", 32'(t_rv - t_g), 32'd3);
      chk("lat1.spacing", 32'(g1[1] - g1[0]), 32'd4);
      chk("lat1.if_rdata", rd1, D);
    end
    repeat (6) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
Shares one single-ported, fixed-latency unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores).
- Arbitrates requests and sequences each access through issue, wait and response phases.
- Drives per-stage stall signals that freeze the pipeline while an access is pending.
- Sits between the fetch/memory stages and the memory macro, replacing their private instruction/data memories.

Parameters:
XLEN, 32, data width
ADDR_W, 32, address width
MEM_LAT, 2, cycles from the mem_en cycle to mem_rdata valid; legal range >= 1
STARVE_MAX, 4, maximum consecutive DM grants while if_req is waiting; 0 = IF wins every tie

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch read request; held high with stable if_addr until if_gnt, may drop after
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle grant pulse to fetch
if_rvalid  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  XLEN  instruction word, held until the next IF response
dm_req  in  1  data request; held with stable fields until dm_gnt
dm_we  in  1  1 = store, 0 = load
dm_addr  in  ADDR_W  data address
dm_wdata  in  XLEN  store data
dm_gnt  out  1  one-cycle grant pulse to the memory stage
dm_rvalid  out  1  one-cycle completion pulse (loads: dm_rdata valid; stores: write acknowledge)
dm_rdata  out  XLEN  load data, held until the next DM load response
stall_if  out  1  freeze fetch
stall_dm  out  1  freeze the memory stage and upstream
mem_en  out  1  memory access strobe, one cycle
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  XLEN  memory write data
mem_rdata  in  XLEN  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; owner, wait counter and starvation counter clear.
  - All outputs are 0, including the rdata registers.
  - An in-flight access is dropped with no rvalid pulse.
- FSM states: IDLE, ISSUE, WAIT, RESP. The owner register is IF or DM.
- IDLE:
  - If any request is pending, pulse the winner's gnt combinationally this cycle.
  - Capture the winner's addr, we and wdata, set owner, and go to ISSUE.
  - With no request, stay in IDLE.
- Arbitration (a tie means both requests pending in IDLE):
  - DM wins a tie unless starve_cnt == STARVE_MAX, in which case IF wins.
  - A single requester always wins.
  - starve_cnt increments on a DM grant while if_req is high, saturating at STARVE_MAX.
  - starve_cnt clears on any IF grant, and on a DM grant while if_req is low.
- ISSUE (1 cycle):
  - mem_en = 1, driving the registered mem_addr, mem_wdata and mem_we.
  - mem_we is 0 for IF accesses.
  - Load the wait counter with MEM_LAT and go to WAIT.
- WAIT (MEM_LAT cycles):
  - mem_en = 0; the counter decrements each cycle.
  - On the final WAIT cycle, register mem_rdata into the owner's rdata register (skipped for stores).
  - Then go to RESP.
- RESP (1 cycle): pulse the owner's rvalid, then go to IDLE.
- Timing for a grant in cycle T:
  - mem_en at T+1.
  - rvalid at T+2+MEM_LAT.
  - Next grant no earlier than T+3+MEM_LAT, giving a throughput of one access per MEM_LAT+3 cycles.
- Stalls:
  - stall_x = x_req OR (owner == x AND state ∈ {ISSUE, WAIT}).
  - stall_x is low in the owner's RESP cycle unless x_req is already reasserted.
- A request arriving while the FSM is not in IDLE waits; there is no grant before IDLE.
- A request present in the RESP cycle is arbitrated in the following IDLE cycle.
- Non-owner rvalid and rdata are unaffected by the other requester's access.
- Requests are never queued: at most one outstanding access in the whole block.
- mem_addr, mem_we and mem_wdata keep their last values outside ISSUE; mem_en is the only qualifier.

Decomposition:
- Shared package, mem_arb_pkg, holds:
  - state enum (IDLE/ISSUE/WAIT/RESP)
  - owner encoding (OWN_IF/OWN_DM)
  - default MEM_LAT and STARVE_MAX constants
- No sub-module is required; the arbiter and FSM fit in one module.
- The wait counter is width $clog2(MEM_LAT+1).

Test Plan:
- IF-only read, MEM_LAT=2, if_addr=0x40, memory returns 0x00500093:
  - if_gnt at T, mem_en at T+1 with mem_addr=0x40 and mem_we=0.
  - if_rvalid with if_rdata=0x00500093 at T+4; stall_if is low at T+4.
- DM store, dm_addr=0x100, dm_wdata=0xDEADBEEF:
  - mem_we=1 and mem_wdata=0xDEADBEEF during mem_en.
  - dm_rvalid pulses at T+4; dm_rdata is unchanged.
- Simultaneous if_req and dm_req in IDLE:
  - dm_gnt first; if_gnt at T+5 (the next IDLE).
  - stall_if stays high from T until if_rvalid.
- Starvation, STARVE_MAX=4, both requesters continuously requesting:
  - Grant sequence is DM,DM,DM,DM,IF,DM,...
  - starve_cnt reads 0 after the IF grant.
- Reset asserted during WAIT of a DM load:
  - All outputs go to 0 immediately; no dm_rvalid is ever produced.
  - After release, a new if_req is granted from IDLE.
- MEM_LAT=1 regression: grant-to-rvalid latency is 3 cycles, and back-to-back accesses are spaced 4 cycles apart.
